// File: rtl/alu_top.sv
// Single-cycle registered ALU: arithmetic, logic, compare and shift units share operands A/B.
// ALU_FUN[3:2] picks the unit, ALU_FUN[1:0] the operation; only the selected unit drives its outputs.
module alu_top #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic [WIDTH-1:0] Arith_OUT,
    output logic             Carry_OUT,
    output logic [WIDTH-1:0] Logic_OUT,
    output logic [WIDTH-1:0] CMP_OUT,
    output logic [WIDTH-1:0] SHIFT_OUT,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             SHIFT_Flag
);

    typedef enum logic [1:0] {
        UnitArith = 2'b00,
        UnitLogic = 2'b01,
        UnitCmp   = 2'b10,
        UnitShift = 2'b11
    } unit_e;

    unit_e            unit;
    logic [WIDTH-1:0] arith_d;
    logic             carry_d;
    logic [WIDTH-1:0] logic_d;
    logic [WIDTH-1:0] cmp_d;
    logic [WIDTH-1:0] shift_d;
    logic             arith_flag_d;
    logic             logic_flag_d;
    logic             cmp_flag_d;
    logic             shift_flag_d;

    assign unit = unit_e'(ALU_FUN[3:2]);

    // Non-selected units stay at zero, so every result defaults to 0 here.
    always_comb begin
        arith_d      = '0;
        carry_d      = 1'b0;
        logic_d      = '0;
        cmp_d        = '0;
        shift_d      = '0;
        arith_flag_d = 1'b0;
        logic_flag_d = 1'b0;
        cmp_flag_d   = 1'b0;
        shift_flag_d = 1'b0;

        unique case (unit)
            UnitArith: begin
                arith_flag_d = 1'b1;
                unique case (ALU_FUN[1:0])
                    2'b00: {carry_d, arith_d} = {1'b0, A} + {1'b0, B};
                    2'b01: begin
                        arith_d = A - B;
                        carry_d = (A < B);
                    end
                    2'b10: arith_d = A * B;
                    2'b11: arith_d = (B == '0) ? '0 : A / B;
                    default: ;
                endcase
            end
            UnitLogic: begin
                logic_flag_d = 1'b1;
                unique case (ALU_FUN[1:0])
                    2'b00: logic_d = A & B;
                    2'b01: logic_d = A | B;
                    2'b10: logic_d = ~(A & B);
                    2'b11: logic_d = ~(A | B);
                    default: ;
                endcase
            end
            UnitCmp: begin
                cmp_flag_d = 1'b1;
                unique case (ALU_FUN[1:0])
                    2'b00: cmp_d = '0;
                    2'b01: cmp_d = (A == B) ? WIDTH'(1) : '0;
                    2'b10: cmp_d = (A > B) ? WIDTH'(2) : '0;
                    2'b11: cmp_d = (A < B) ? WIDTH'(3) : '0;
                    default: ;
                endcase
            end
            UnitShift: begin
                shift_flag_d = 1'b1;
                unique case (ALU_FUN[1:0])
                    2'b00: shift_d = A >> 1;
                    2'b01: shift_d = A << 1;
                    2'b10: shift_d = B >> 1;
                    2'b11: shift_d = B << 1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            Arith_OUT  <= '0;
            Carry_OUT  <= 1'b0;
            Logic_OUT  <= '0;
            CMP_OUT    <= '0;
            SHIFT_OUT  <= '0;
            Arith_Flag <= 1'b0;
            Logic_Flag <= 1'b0;
            CMP_Flag   <= 1'b0;
            SHIFT_Flag <= 1'b0;
        end else begin
            Arith_OUT  <= arith_d;
            Carry_OUT  <= carry_d;
            Logic_OUT  <= logic_d;
            CMP_OUT    <= cmp_d;
            SHIFT_OUT  <= shift_d;
            Arith_Flag <= arith_flag_d;
            Logic_Flag <= logic_flag_d;
            CMP_Flag   <= cmp_flag_d;
            SHIFT_Flag <= shift_flag_d;
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: expected output words are queued as stimulus is driven
// and compared one cycle later against the registered outputs.
module tb_alu_top;

    typedef logic [68:0] vec_t;

    logic        Clk = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  ALU_FUN = '0;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
    logic        Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;

    int   vectors = 0;
    int   fails = 0;
    vec_t exp_q[$];

    alu_top #(.WIDTH(16)) dut (
        .Clk        (Clk),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Logic_OUT  (Logic_OUT),
        .CMP_OUT    (CMP_OUT),
        .SHIFT_OUT  (SHIFT_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_Flag (Logic_Flag),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_Flag (SHIFT_Flag)
    );

    always #5 Clk = ~Clk;

    // Packed word layout: {arith, carry, logic, cmp, shift, flags{arith,logic,cmp,shift}}
    function automatic vec_t mk(logic [15:0] ar, logic c, logic [15:0] lo, logic [15:0] cm,
                                logic [15:0] sh, logic [3:0] fl);
        return {ar, c, lo, cm, sh, fl};
    endfunction

    function automatic vec_t observe();
        return {Arith_OUT, Carry_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
                Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag};
    endfunction

    // Reference model written from the operation table, used for random vectors.
    function automatic vec_t model(logic [15:0] a, logic [15:0] b, logic [3:0] f);
        logic [16:0] s;
        logic [31:0] p;
        vec_t        r;
        s = {1'b0, a} + {1'b0, b};
        p = {16'h0, a} * {16'h0, b};
        r = '0;
        case (f)
            4'h0: r = mk(s[15:0], s[16], 16'h0, 16'h0, 16'h0, 4'b1000);
            4'h1: r = mk(a - b, (a < b), 16'h0, 16'h0, 16'h0, 4'b1000);
            4'h2: r = mk(p[15:0], 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);
            4'h3: r = mk((b == 16'h0) ? 16'h0 : a / b, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);
            4'h4: r = mk(16'h0, 1'b0, a & b, 16'h0, 16'h0, 4'b0100);
            4'h5: r = mk(16'h0, 1'b0, a | b, 16'h0, 16'h0, 4'b0100);
            4'h6: r = mk(16'h0, 1'b0, ~(a & b), 16'h0, 16'h0, 4'b0100);
            4'h7: r = mk(16'h0, 1'b0, ~(a | b), 16'h0, 16'h0, 4'b0100);
            4'h8: r = mk(16'h0, 1'b0, 16'h0, 16'h0, 16'h0, 4'b0010);
            4'h9: r = mk(16'h0, 1'b0, 16'h0, (a == b) ? 16'd1 : 16'd0, 16'h0, 4'b0010);
            4'hA: r = mk(16'h0, 1'b0, 16'h0, (a > b) ? 16'd2 : 16'd0, 16'h0, 4'b0010);
            4'hB: r = mk(16'h0, 1'b0, 16'h0, (a < b) ? 16'd3 : 16'd0, 16'h0, 4'b0010);
            4'hC: r = mk(16'h0, 1'b0, 16'h0, 16'h0, {1'b0, a[15:1]}, 4'b0001);
            4'hD: r = mk(16'h0, 1'b0, 16'h0, 16'h0, {a[14:0], 1'b0}, 4'b0001);
            4'hE: r = mk(16'h0, 1'b0, 16'h0, 16'h0, {1'b0, b[15:1]}, 4'b0001);
            default: r = mk(16'h0, 1'b0, 16'h0, 16'h0, {b[14:0], 1'b0}, 4'b0001);
        endcase
        return r;
    endfunction

    // Drive inputs away from the edge, queue the expectation, sample just after the edge.
    task automatic drive(logic [15:0] a, logic [15:0] b, logic [3:0] f, vec_t e);
        @(negedge Clk);
        A = a;
        B = b;
        ALU_FUN = f;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t got;
        RST = 1'b0;
        #2;
        got = observe();
        vectors++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_async got=%h exp=0", got);
        end
        repeat (2) @(posedge Clk);
        #1;
        got = observe();
        vectors++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_held got=%h exp=0", got);
        end
        @(negedge Clk);
        RST = 1'b1;
    endtask

    task automatic test_arith();
        logic [15:0] res[4];
        vec_t        got, e;
        res = '{16'd21, 16'd7, 16'd98, 16'd2};
        for (int i = 0; i < 4; i++) begin
            drive(16'd14, 16'd7, 4'(i), mk(res[i], 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000));
            got = observe();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                fails++;
                $display("FAIL arith fun=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_logic();
        logic [15:0] res[4];
        vec_t        got, e;
        res = '{16'h0006, 16'h000F, 16'hFFF9, 16'hFFF0};
        for (int i = 0; i < 4; i++) begin
            drive(16'd14, 16'd7, 4'(4 + i), mk(16'h0, 1'b0, res[i], 16'h0, 16'h0, 4'b0100));
            got = observe();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                fails++;
                $display("FAIL logic fun=%0d got=%h exp=%h", 4 + i, got, e);
            end
        end
    endtask

    task automatic test_compare();
        logic [15:0] ta[5], tb[5], res[5];
        logic [3:0]  tf[5];
        vec_t        got, e;
        ta  = '{16'd5, 16'd10, 16'd11, 16'd10, 16'd11};
        tb  = '{16'd5, 16'd10, 16'd10, 16'd11, 16'd10};
        tf  = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hB};
        res = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], tb[i], tf[i], mk(16'h0, 1'b0, 16'h0, res[i], 16'h0, 4'b0010));
            got = observe();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                fails++;
                $display("FAIL compare case=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_shift();
        logic [15:0] ta[5], tb[5], res[5];
        logic [3:0]  tf[5];
        vec_t        got, e;
        ta  = '{16'd12, 16'd12, 16'd3, 16'd3, 16'h8000};
        tb  = '{16'd9, 16'd9, 16'd28, 16'd28, 16'd1};
        tf  = '{4'hC, 4'hD, 4'hE, 4'hF, 4'hD};
        res = '{16'd6, 16'd24, 16'd14, 16'd56, 16'd0};
        for (int i = 0; i < 5; i++) begin
            drive(ta[i], tb[i], tf[i], mk(16'h0, 1'b0, 16'h0, 16'h0, res[i], 4'b0001));
            got = observe();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                fails++;
                $display("FAIL shift case=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_boundary();
        logic [15:0] ta[3], tb[3];
        logic [3:0]  tf[3];
        vec_t        te[3];
        vec_t        got, e;
        ta = '{16'hFFFF, 16'd3, 16'd1234};
        tb = '{16'd1, 16'd5, 16'd0};
        tf = '{4'h0, 4'h1, 4'h3};
        te[0] = mk(16'h0000, 1'b1, 16'h0, 16'h0, 16'h0, 4'b1000);
        te[1] = mk(16'hFFFE, 1'b1, 16'h0, 16'h0, 16'h0, 4'b1000);
        te[2] = mk(16'h0000, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            drive(ta[i], tb[i], tf[i], te[i]);
            got = observe();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                fails++;
                $display("FAIL boundary case=%0d got=%h exp=%h", i, got, e);
            end
        end
    endtask

    // Mid-cycle ALU_FUN changes must not leak into the registered result.
    task automatic test_back_to_back();
        vec_t        got, e;
        logic [15:0] a, b;
        logic [3:0]  f;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = (i % 8 == 0) ? 16'h0 : 16'($urandom);
            f = 4'($urandom_range(0, 15));
            drive(a, b, f, model(a, b, f));
            got = observe();
            ALU_FUN = ~f;
            #2;
            e = exp_q.pop_front();
            vectors++;
            if (got !== e || observe() !== e) begin
                fails++;
                $display("FAIL random a=%h b=%h fun=%h got=%h exp=%h", a, b, f, got, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        vec_t got, e;
        @(negedge Clk);
        A = 16'd100;
        B = 16'd23;
        ALU_FUN = 4'h0;
        #1;
        RST = 1'b0;
        #1;
        got = observe();
        vectors++;
        if (got !== '0) begin
            fails++;
            $display("FAIL mid_reset_async got=%h exp=0", got);
        end
        @(posedge Clk);
        #1;
        got = observe();
        vectors++;
        if (got !== '0) begin
            fails++;
            $display("FAIL mid_reset_held got=%h exp=0", got);
        end
        @(negedge Clk);
        RST = 1'b1;
        drive(16'd100, 16'd23, 4'h0, mk(16'd123, 1'b0, 16'h0, 16'h0, 16'h0, 4'b1000));
        got = observe();
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
            fails++;
            $display("FAIL post_reset got=%h exp=%h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_compare();
        test_shift();
        test_boundary();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
